// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request channel plus the decode-side handshake.
// master = fetch unit, slave = memory/processor environment.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory reads, show-ahead prefetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall
`endif
);

  localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_after;
  logic              valid_q, valid_d;
  entry_t            head_q, head_d, new_entry;
  entry_t            fifo_q [DEPTH];
  logic              push, pop;

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = head_q.data;
  assign bus.instr_pc    = head_q.pc;

  // Next-state: redirect flushes everything; otherwise issue/accept/discard per state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = valid_q & bus.instr_ready;
    new_entry  = '{data: bus.mem_rdata, pc: mem_addr_q};
    cnt_after  = cnt_q + CNT_W'(1) - CNT_W'(pop);

    if (bus.redirect) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      pc_d  = bus.redirect_pc;
      case (state_q)
        S_IDLE: begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.redirect_pc;
        end
        S_REQ, S_DISCARD: begin
          // An unacked request must be held until its ack, whose data is then dropped.
          if (bus.mem_ack) begin
            state_d    = S_REQ;
            mem_addr_d = bus.redirect_pc;
          end else begin
            state_d = S_DISCARD;
          end
        end
        default: begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end else begin
      if (pop) rd_d = rd_q + PTR_W'(1);
      case (state_q)
        S_IDLE: begin
          if (cnt_q < FULL_CNT) begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            push = 1'b1;
            wr_d = wr_q + PTR_W'(1);
            pc_d = pc_q + ADDR_W'(1);
            if (cnt_after < FULL_CNT) begin
              mem_addr_d = pc_q + ADDR_W'(1);
            end else begin
              state_d   = S_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (bus.mem_ack) begin
            state_d    = S_REQ;
            mem_addr_d = pc_q;
          end
        end
        default: begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Head register bypasses the incoming word when it lands straight at the read slot.
    valid_d = (cnt_d != '0);
    head_d  = (push && (wr_q == rd_d)) ? new_entry : fifo_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_q] <= new_entry;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push && (perf_fetched_q != 16'hFFFF)) perf_fetched_q <= perf_fetched_q + 16'd1;
      if (!valid_q && (perf_stall_q != 16'hFFFF)) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model checked every cycle plus directed literal checks.
module tb_instr_fetch_unit;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 4;
  localparam logic [7:0]  RST_PC0 = 8'h00;
  localparam logic [7:0]  RST_PC1 = 8'hFE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ack_delay = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b0 ();
  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched0, perf_stall0, perf_fetched1, perf_stall1;
`endif

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RST_PC0)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(b0)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched0),
    .perf_stall(perf_stall0)
`endif
  );

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RST_PC1)) u_dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(b1)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched1),
    .perf_stall(perf_stall1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory for b0: acks after ack_delay wait cycles, data = 0x1000 + address.
  initial begin
    int wait_cnt;
    wait_cnt     = 0;
    b0.mem_ack   = 1'b0;
    b0.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (b0.mem_req && (wait_cnt >= ack_delay)) begin
        b0.mem_ack   = 1'b1;
        b0.mem_rdata = 16'h1000 + 16'(b0.mem_addr);
        wait_cnt     = 0;
      end else begin
        b0.mem_ack   = 1'b0;
        b0.mem_rdata = 16'hDEAD;
        wait_cnt     = b0.mem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  // Memory for b1: zero-wait, data = 0x2000 + address; consumer always ready.
  initial begin
    b1.instr_ready = 1'b1;
    b1.redirect    = 1'b0;
    b1.redirect_pc = '0;
    b1.mem_ack     = 1'b0;
    b1.mem_rdata   = '0;
    forever begin
      @(negedge clk);
      b1.mem_ack   = b1.mem_req;
      b1.mem_rdata = 16'h2000 + 16'(b1.mem_addr);
    end
  end

  // Reference model for b0: expected fetch address stream and queue of instructions owed to decode.
  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  pc;
  } exp_t;

  initial begin
    exp_t        mq[$];
    logic [7:0]  m_pc, m_held;
    bit          m_disc;
    logic        p_rst, p_req, p_ack, p_ready, p_redir;
    logic [7:0]  p_addr, p_rpc;
    logic [15:0] p_rdata;
    m_pc   = RST_PC0;
    m_held = '0;
    m_disc = 1'b0;
    forever begin
      @(posedge clk);
      p_rst   = rst;
      p_req   = b0.mem_req;
      p_ack   = b0.mem_ack;
      p_addr  = b0.mem_addr;
      p_rdata = b0.mem_rdata;
      p_ready = b0.instr_ready;
      p_redir = b0.redirect;
      p_rpc   = b0.redirect_pc;
      #1;
      if (p_rst) begin
        mq.delete();
        m_pc   = RST_PC0;
        m_disc = 1'b0;
        check("reset mem_req", b0.mem_req, 0);
        check("reset mem_addr", b0.mem_addr, RST_PC0);
        check("reset instr_valid", b0.instr_valid, 0);
        check("reset instr", b0.instr, 0);
        check("reset instr_pc", b0.instr_pc, 0);
      end else begin
        if (p_ready && (mq.size() != 0)) void'(mq.pop_front());
        if (p_redir) begin
          mq.delete();
          m_pc = p_rpc;
          if (p_req && !p_ack) begin
            if (!m_disc) m_held = p_addr;
            m_disc = 1'b1;
          end else begin
            m_disc = 1'b0;
          end
        end else if (p_req && p_ack) begin
          if (m_disc) begin
            m_disc = 1'b0;
          end else begin
            mq.push_back('{data: p_rdata, pc: m_pc});
            m_pc = m_pc + 8'd1;
          end
        end
        check("model instr_valid", b0.instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          check("model instr", b0.instr, mq[0].data);
          check("model instr_pc", b0.instr_pc, mq[0].pc);
        end
        if (b0.mem_req) check("model mem_addr", b0.mem_addr, m_disc ? m_held : m_pc);
        if (p_req && !p_ack) check("model req held until ack", b0.mem_req, 1);
        if (!m_disc && (mq.size() == DEPTH)) check("model no req when full", b0.mem_req, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wrap_pc [4];
    int         n_req;
    bit         found;
    wrap_pc[0] = 8'hFE;
    wrap_pc[1] = 8'hFF;
    wrap_pc[2] = 8'h00;
    wrap_pc[3] = 8'h01;
    b0.instr_ready = 1'b1;
    b0.redirect    = 1'b0;
    b0.redirect_pc = '0;

    // Reset, then zero-wait streaming at one instruction per cycle.
    rst = 1'b1;
    tick();
    tick();
    check("reset req", b0.mem_req, 0);
    check("reset valid", b0.instr_valid, 0);
    check("wrap reset mem_addr", b1.mem_addr, 8'hFE);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("stream mem_req", b0.mem_req, 1);
      check("stream mem_addr", b0.mem_addr, 32'(k - 1));
      if (k >= 2) begin
        check("stream valid", b0.instr_valid, 1);
        check("stream instr", b0.instr, 32'h1000 + 32'(k - 2));
        check("stream instr_pc", b0.instr_pc, 32'(k - 2));
        check("wrap instr_pc", b1.instr_pc, wrap_pc[k-2]);
        check("wrap instr", b1.instr, 32'h2000 + 32'(wrap_pc[k-2]));
      end
    end
    repeat (4) tick();

    // Stalled consumer: exactly DEPTH requests, head held, then in-order drain.
    rst = 1'b1;
    b0.instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    n_req = 0;
    repeat (10) begin
      tick();
      if (b0.mem_req) n_req++;
    end
    check("stall request count", n_req, 4);
    check("stall mem_req", b0.mem_req, 0);
    check("stall valid", b0.instr_valid, 1);
    check("stall head", b0.instr, 16'h1000);
    b0.instr_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("drain instr", b0.instr, 32'h1000 + 32'(k));
    end
    repeat (3) tick();

    // Redirect from a full, idle FIFO with the head consumed the same cycle.
    b0.instr_ready = 1'b0;
    repeat (8) tick();
    check("full idle req", b0.mem_req, 0);
    b0.redirect    = 1'b1;
    b0.redirect_pc = 8'h80;
    b0.instr_ready = 1'b1;
    tick();
    b0.redirect = 1'b0;
    check("idle redirect valid", b0.instr_valid, 0);
    check("idle redirect req", b0.mem_req, 1);
    check("idle redirect addr", b0.mem_addr, 8'h80);
    tick();
    check("idle redirect instr_pc", b0.instr_pc, 8'h80);
    check("idle redirect instr", b0.instr, 16'h1080);
    repeat (3) tick();

    // Slow memory, redirect in the second wait cycle of a request.
    rst = 1'b1;
    ack_delay = 3;
    tick();
    rst = 1'b0;
    tick();
    check("slow first addr", b0.mem_addr, 8'h00);
    tick();
    b0.redirect    = 1'b1;
    b0.redirect_pc = 8'h40;
    tick();
    b0.redirect = 1'b0;
    check("discard req held", b0.mem_req, 1);
    check("discard addr held", b0.mem_addr, 8'h00);
    tick();
    check("discard addr held at ack", b0.mem_addr, 8'h00);
    tick();
    check("post-discard req", b0.mem_req, 1);
    check("post-discard addr", b0.mem_addr, 8'h40);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b0.instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("redirect instr appears", found, 1);
    if (found) begin
      check("redirect first instr_pc", b0.instr_pc, 8'h40);
      check("redirect first instr", b0.instr, 16'h1040);
    end
    ack_delay = 0;
    repeat (4) tick();

    // Reset while a request is live and two entries are buffered.
    rst = 1'b1;
    b0.instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("pre-reset req", b0.mem_req, 1);
    check("pre-reset valid", b0.instr_valid, 1);
    rst = 1'b1;
    tick();
    check("mid reset req", b0.mem_req, 0);
    check("mid reset valid", b0.instr_valid, 0);
    check("mid reset addr", b0.mem_addr, RST_PC0);
    rst = 1'b0;
    b0.instr_ready = 1'b1;
    repeat (6) tick();

`ifdef FETCH_PERF_EN
    // One-wait first fetch gives three empty cycles, then eight fetches.
    rst = 1'b1;
    ack_delay = 1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    ack_delay = 0;
    repeat (8) tick();
    check("perf_fetched", perf_fetched0, 16'd8);
    check("perf_stall", perf_stall0, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
